// File: rtl/mmio_store_uart_tx.sv
// 8N1 UART transmitter that snoops the core's data-store port: stores to TX_ADDR queue a byte,
// stores to CTRL_ADDR clear the sticky overflow flag.
module mmio_store_uart_tx #(
    parameter int          BAUD_DIV   = 434,
    parameter logic [11:0] TX_ADDR    = 12'hFFF,
    parameter logic [11:0] CTRL_ADDR  = 12'hFFE,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_en,
    input  logic [11:0] st_addr,
    input  logic [31:0] st_data,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    state_reg;
    logic [BW-1:0] baud_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          ovf_reg;

    logic       push_req;
    logic       ctrl_wr;
    logic       fifo_empty;
    logic       fifo_full;
    logic       bit_end;
    logic       pop;
    logic       push;
    logic [7:0] fifo_head;
    logic       unused_st_data;

    assign push_req   = st_en && (st_addr == TX_ADDR);
    assign ctrl_wr    = st_en && (st_addr == CTRL_ADDR);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign bit_end    = (baud_reg == '0);
    // A pop also happens at the end of STOP so consecutive frames run with no idle cycle.
    assign pop        = !fifo_empty && ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));
    assign push       = push_req && (!fifo_full || pop);
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    assign unused_st_data = ^st_data[31:8];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= st_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (ctrl_wr) begin
                ovf_reg <= 1'b0;
            end else if (push_req && !push) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // tx is driven from the state being entered, so it changes on the same edge as the FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        baud_reg  <= BAUD_LOAD;
                        state_reg <= ST_START;
                        tx_reg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg   <= ST_DATA;
                        bit_idx_reg <= '0;
                        baud_reg    <= BAUD_LOAD;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_reg <= BAUD_LOAD;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        baud_reg <= baud_reg - 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_reg <= fifo_head;
                            baud_reg  <= BAUD_LOAD;
                            state_reg <= ST_START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg - 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = !fifo_empty || (state_reg != ST_IDLE);
    assign full = fifo_full;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_mmio_store_uart_tx.sv
// Scoreboarded bench: stimulus queues expected bytes, a negedge UART receiver pops and compares frames.
module tb_mmio_store_uart_tx;

    localparam int BAUD = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        st_en = 1'b0;
    logic [11:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        tx;
    logic        busy;
    logic        full;
    logic        ovf;

    mmio_store_uart_tx #(
        .BAUD_DIV  (BAUD),
        .TX_ADDR   (12'hFFF),
        .CTRL_ADDR (12'hFFE),
        .FIFO_DEPTH(8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .st_en  (st_en),
        .st_addr(st_addr),
        .st_data(st_data),
        .tx     (tx),
        .busy   (busy),
        .full   (full),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         miscompares = 0;
    int         frames_seen = 0;
    bit         chk_gap = 1'b0;
    bit         have_prev = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle store; called 1 time unit after a posedge, returns 1 time unit after the next.
    task automatic store(input logic [11:0] addr, input logic [7:0] data);
        st_en   = 1'b1;
        st_addr = addr;
        st_data = {24'hDEAD_BE, data};
        @(posedge clk);
        #1;
        st_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check("drain", {31'd0, busy}, 32'd0);
    endtask

    // Receiver: counts negedges from the first low sample of the start bit.
    initial begin
        int         rx_cnt;
        bit         rx_active;
        logic [7:0] rx_byte;
        logic       rx_start_ok;
        int         prev_start;
        logic [7:0] e;
        rx_active = 1'b0;
        rx_cnt = 0;
        rx_byte = '0;
        rx_start_ok = 1'b0;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rx_active = 1'b0;
                have_prev = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt = 0;
                    if (chk_gap && have_prev) check("gap", cyc - prev_start, 40);
                    prev_start = cyc;
                    have_prev = 1'b1;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 2) rx_start_ok = (tx === 1'b0);
                if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % BAUD) == 0)
                    rx_byte[(rx_cnt - 6) / BAUD] = tx;
                if (rx_cnt == 38) begin
                    frames_seen++;
                    $display("frame rx %02h stop=%0b cycle %0d", rx_byte, tx, cyc);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame: got unexpected byte %02h, want none", rx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", {22'd0, rx_start_ok, tx, rx_byte}, {22'd0, 2'b11, e});
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic [7:0] d;

        // Reset state
        step(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        resetn = 1'b1;
        step(2);

        // 1: single byte, latency and frame length
        exp_q.push_back(8'h41);
        store(12'hFFF, 8'h41);
        check("t1_tx_pre", {31'd0, tx}, 32'd1);
        step(1);
        check("t1_tx_start", {31'd0, tx}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        step(39);
        check("t1_busy_39", {31'd0, busy}, 32'd1);
        step(1);
        check("t1_busy_40", {31'd0, busy}, 32'd0);
        step(2);

        // 2: store to an unrelated address
        store(12'h123, 8'h55);
        step(3);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_tx", {31'd0, tx}, 32'd1);
        check("t2_full", {31'd0, full}, 32'd0);

        // 3: burst of ten, last one overflows
        chk_gap = 1'b1;
        have_prev = 1'b0;
        f0 = frames_seen;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'(i));
            store(12'hFFF, 8'(i));
        end
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_ovf_pre", {31'd0, ovf}, 32'd0);
        store(12'hFFF, 8'h09);
        check("t3_ovf", {31'd0, ovf}, 32'd1);
        wait_idle(500);
        step(2);
        chk_gap = 1'b0;
        check("t3_frames", frames_seen - f0, 9);
        check("t3_ovf_sticky", {31'd0, ovf}, 32'd1);

        // 4: clear ovf, then push on the exact cycle of a pop while full
        store(12'hFFE, 8'h00);
        check("t4_ovf_clr", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            store(12'hFFF, 8'h10 + 8'(i));
        end
        check("t4_full", {31'd0, full}, 32'd1);
        step(32);
        exp_q.push_back(8'h19);
        store(12'hFFF, 8'h19);
        check("t4_pushpop_ovf", {31'd0, ovf}, 32'd0);
        check("t4_pushpop_full", {31'd0, full}, 32'd1);
        store(12'hFFF, 8'h77);
        check("t4_drop_ovf", {31'd0, ovf}, 32'd1);
        store(12'hFFE, 8'h00);
        check("t4_ovf_clr2", {31'd0, ovf}, 32'd0);
        wait_idle(600);
        step(2);

        // 5: reset mid-DATA of 0xA5 with three bytes queued
        store(12'hFFF, 8'hA5);
        store(12'hFFF, 8'h11);
        store(12'hFFF, 8'h22);
        store(12'hFFF, 8'h33);
        step(16);
        check("t5_pre_tx", {31'd0, tx}, 32'd0);
        resetn = 1'b0;
        #1;
        check("t5_tx", {31'd0, tx}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_full", {31'd0, full}, 32'd0);
        check("t5_ovf", {31'd0, ovf}, 32'd0);
        step(2);
        resetn = 1'b1;
        step(2);
        check("t5_busy_after", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h3C);
        store(12'hFFF, 8'h3C);
        wait_idle(100);
        step(2);

        // 6: slow pushes across pointer wrap
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 37 + 5);
            exp_q.push_back(d);
            store(12'hFFF, d);
            step(41);
        end
        wait_idle(200);
        step(4);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
